axis_packetizer: RTL and testbench

//  Single-clock AXI-Stream conditioner placed directly upstream of each axis_mesh input port (axis_in_*).

---
 rtl/axis_packetizer.sv | 162 ++++++++++++++++
 tb/tb_axis_packetizer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packetizer.sv
// axis_packetizer: AXI-Stream conditioner in front of a mesh input port.
// Re-frames packets so that none exceeds MAX_BEATS beats and tdest never
// changes inside a packet. A held beat that has waited IDLE_TIMEOUT idle
// cycles is closed. One lookahead hold register (H) decides tlast; a
// registered output stage (O) drives the mesh.
module axis_packetizer #(
    parameter int TDATA_WIDTH  = 32,
    parameter int TDEST_WIDTH  = 4,
    parameter int MAX_BEATS    = 4,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic [CNT_WIDTH-1:0]   stat_pkts,
    output logic [CNT_WIDTH-1:0]   stat_forced
);

    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    // Hold register H
    logic                   h_valid_q, h_valid_d;
    logic [TDATA_WIDTH-1:0] h_data_q, h_data_d;
    logic [TDEST_WIDTH-1:0] h_dest_q, h_dest_d;
    logic                   h_last_q, h_last_d;
    // Output register O
    logic                   o_valid_q, o_valid_d;
    logic [TDATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [TDEST_WIDTH-1:0] o_dest_q, o_dest_d;
    logic                   o_last_q, o_last_d;
    // Framing and statistics state
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [CNT_WIDTH-1:0]   pkts_q, pkts_d;
    logic [CNT_WIDTH-1:0]   forced_q, forced_d;

    logic out_free;
    logic h_final;
    logic h_move;
    logic s_ready;
    logic accept;
    logic move_last;

    // Handshake decisions: H leaves when O can take it and either H already
    // knows it ends the packet or an incoming beat supplies the lookahead.
    // The idle counter saturates at its limit, which makes the timeout sticky
    // until H moves or a beat is accepted.
    always_comb begin
        out_free  = !o_valid_q | m_axis_tready;
        h_final   = h_valid_q & (h_last_q | (beat_cnt_q == BEAT_LAST) |
                                 (idle_cnt_q == IDLE_LAST));
        h_move    = h_valid_q & out_free & (h_final | s_axis_tvalid);
        s_ready   = !rst & (!h_valid_q | h_move);
        accept    = s_axis_tvalid & s_ready;
        move_last = h_final | (s_axis_tdest != h_dest_q);
    end

    // Next-state computation for H, O, the framing counters and statistics.
    always_comb begin
        h_valid_d  = h_valid_q;
        h_data_d   = h_data_q;
        h_dest_d   = h_dest_q;
        h_last_d   = h_last_q;
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        o_dest_d   = o_dest_q;
        o_last_d   = o_last_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        pkts_d     = pkts_q;
        forced_d   = forced_q;

        if (accept) begin
            h_valid_d = 1'b1;
            h_data_d  = s_axis_tdata;
            h_dest_d  = s_axis_tdest;
            h_last_d  = s_axis_tlast;
        end else if (h_move) begin
            h_valid_d = 1'b0;
        end

        if (out_free) begin
            o_valid_d = h_move;
            if (h_move) begin
                o_data_d = h_data_q;
                o_dest_d = h_dest_q;
                o_last_d = move_last;
            end
        end

        if (h_move) begin
            if (move_last) begin
                beat_cnt_d = '0;
                pkts_d     = pkts_q + 1'b1;
                if (!h_last_q) begin
                    forced_d = forced_q + 1'b1;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        if (accept || h_move) begin
            idle_cnt_d = '0;
        end else if (h_valid_q && (idle_cnt_q != IDLE_LAST)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    // State registers; reset drops any held beat and clears statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_valid_q  <= 1'b0;
            h_data_q   <= '0;
            h_dest_q   <= '0;
            h_last_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_dest_q   <= '0;
            o_last_q   <= 1'b0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
            pkts_q     <= '0;
            forced_q   <= '0;
        end else begin
            h_valid_q  <= h_valid_d;
            h_data_q   <= h_data_d;
            h_dest_q   <= h_dest_d;
            h_last_q   <= h_last_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_dest_q   <= o_dest_d;
            o_last_q   <= o_last_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            pkts_q     <= pkts_d;
            forced_q   <= forced_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = o_valid_q;
    assign m_axis_tdata  = o_data_q;
    assign m_axis_tlast  = o_last_q;
    assign m_axis_tdest  = o_dest_q;
    assign stat_pkts     = pkts_q;
    assign stat_forced   = forced_q;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed testbench for axis_packetizer (default parameters).
module tb_axis_packetizer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sTvalid;
   logic        sTready;
   logic [31:0] sTdata;
   logic        sTlast;
   logic [3:0]  sTdest;
   logic        mTvalid;
   logic        mTready;
   logic [31:0] mTdata;
   logic        mTlast;
   logic [3:0]  mTdest;
   logic [15:0] statPkts;
   logic [15:0] statForced;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] outQ[$];
   logic [63:0] expQ[$];

   axis_packetizer dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (sTvalid),
      .s_axis_tready (sTready),
      .s_axis_tdata  (sTdata),
      .s_axis_tlast  (sTlast),
      .s_axis_tdest  (sTdest),
      .m_axis_tvalid (mTvalid),
      .m_axis_tready (mTready),
      .m_axis_tdata  (mTdata),
      .m_axis_tlast  (mTlast),
      .m_axis_tdest  (mTdest),
      .stat_pkts     (statPkts),
      .stat_forced   (statForced)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Record every beat the mesh side will take at the coming rising edge.
   always @(negedge clk) begin
      if (!rst && mTvalid && mTready)
         outQ.push_back({27'd0, mTlast, mTdest, mTdata});
   end

   // Safety net so a stuck run still ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] beat(input logic l, input logic [3:0] d, input logic [31:0] x);
      return {27'd0, l, d, x};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("[TB] %s check failed", tag);
      end
   endtask

   // Compare the captured output beats against the expected list.
   task automatic checkQueue(input string tag);
      checkOutput({tag, "_count"}, 64'(outQ.size()), 64'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++)
         checkOutput($sformatf("%s_beat%0d", tag, i + 1), outQ[i], expQ[i]);
   endtask

   // Offer one upstream beat and hold it until accepted (bounded wait).
   task automatic applyStimulus(input logic [31:0] d, input logic [3:0] dst, input logic l);
      logic gotReady = 1'b0;
      sTvalid = 1'b1;
      sTdata  = d;
      sTdest  = dst;
      sTlast  = l;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (sTready) begin
            gotReady = 1'b1;
            break;
         end
      end
      checkOutput($sformatf("ready_wait_%0h", d), 64'(gotReady), 64'd1);
      @(posedge clk);
      #1;
      sTvalid = 1'b0;
   endtask

   initial begin
      sTvalid = 1'b0;
      sTdata  = '0;
      sTdest  = '0;
      sTlast  = 1'b0;
      mTready = 1'b1;
      rst     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_tvalid", 64'(mTvalid), 64'd0);
      checkOutput("rst_tready", 64'(sTready), 64'd0);
      checkOutput("rst_tdata", 64'(mTdata), 64'd0);
      checkOutput("rst_pkts", 64'(statPkts), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_tready", 64'(sTready), 64'd1);
      @(posedge clk);
      #1;

      // Single final beat: visible one edge after it lands in H.
      applyStimulus(32'h1, 4'd1, 1'b1);
      checkOutput("t1_not_yet", 64'(mTvalid), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("t1_tvalid", 64'(mTvalid), 64'd1);
      checkOutput("t1_beat", beat(mTlast, mTdest, mTdata), beat(1'b1, 4'd1, 32'h1));
      checkOutput("t1_pkts", 64'(statPkts), 64'd1);
      checkOutput("t1_forced", 64'(statForced), 64'd0);
      repeat (3) @(posedge clk);
      #1;

      // Ten beats to one destination: capped at four beats per packet.
      outQ.delete();
      for (int i = 1; i <= 10; i++)
         applyStimulus(32'h200 + 32'(i), 4'd3, i == 10);
      repeat (4) @(posedge clk);
      #1;
      expQ.delete();
      for (int i = 1; i <= 10; i++)
         expQ.push_back(beat(i == 4 || i == 8 || i == 10, 4'd3, 32'h200 + 32'(i)));
      checkQueue("t2");
      checkOutput("t2_pkts", 64'(statPkts), 64'd4);
      checkOutput("t2_forced", 64'(statForced), 64'd2);

      // Destination change closes the running packet.
      outQ.delete();
      applyStimulus(32'h301, 4'd2, 1'b0);
      applyStimulus(32'h302, 4'd2, 1'b0);
      applyStimulus(32'h303, 4'd3, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      expQ = '{beat(1'b0, 4'd2, 32'h301), beat(1'b1, 4'd2, 32'h302), beat(1'b1, 4'd3, 32'h303)};
      checkQueue("t3");
      checkOutput("t3_pkts", 64'(statPkts), 64'd6);
      checkOutput("t3_forced", 64'(statForced), 64'd3);

      // Lone non-final beat: closed by the idle timeout, silent before that.
      outQ.delete();
      applyStimulus(32'hAB, 4'd7, 1'b0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checkOutput($sformatf("t4_quiet%0d", i), 64'(mTvalid), 64'd0);
      end
      @(negedge clk);
      checkOutput("t4_tvalid", 64'(mTvalid), 64'd1);
      checkOutput("t4_beat", beat(mTlast, mTdest, mTdata), beat(1'b1, 4'd7, 32'hAB));
      checkOutput("t4_pkts", 64'(statPkts), 64'd7);
      checkOutput("t4_forced", 64'(statForced), 64'd4);
      repeat (3) @(posedge clk);
      #1;

      // Output stall mid-stream: two beats buffered, O frozen, the held
      // beat times out during the stall and closes its packet on release.
      outQ.delete();
      applyStimulus(32'h501, 4'd5, 1'b0);
      applyStimulus(32'h502, 4'd5, 1'b0);
      applyStimulus(32'h503, 4'd5, 1'b0);
      mTready = 1'b0;
      sTvalid = 1'b1;
      sTdata  = 32'h504;
      sTdest  = 4'd5;
      sTlast  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput($sformatf("t5_tready%0d", i), 64'(sTready), 64'd0);
         checkOutput($sformatf("t5_hold%0d", i), {31'd0, mTvalid, mTdata}, {31'd0, 1'b1, 32'h502});
      end
      @(posedge clk);
      #1;
      mTready = 1'b1;
      for (int i = 4; i <= 8; i++)
         applyStimulus(32'h500 + 32'(i), 4'd5, i == 8);
      repeat (4) @(posedge clk);
      #1;
      expQ.delete();
      for (int i = 1; i <= 8; i++)
         expQ.push_back(beat(i == 3 || i == 7 || i == 8, 4'd5, 32'h500 + 32'(i)));
      checkQueue("t5");
      checkOutput("t5_pkts", 64'(statPkts), 64'd10);
      checkOutput("t5_forced", 64'(statForced), 64'd6);

      // Asynchronous reset mid-packet, then a fresh four-beat packet.
      applyStimulus(32'h601, 4'd9, 1'b0);
      applyStimulus(32'h602, 4'd9, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("t6_tvalid", 64'(mTvalid), 64'd0);
      checkOutput("t6_tready", 64'(sTready), 64'd0);
      checkOutput("t6_tdata", 64'(mTdata), 64'd0);
      checkOutput("t6_pkts", 64'(statPkts), 64'd0);
      checkOutput("t6_forced", 64'(statForced), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      outQ.delete();
      for (int i = 1; i <= 4; i++)
         applyStimulus(32'h610 + 32'(i), 4'd9, i == 4);
      repeat (4) @(posedge clk);
      #1;
      expQ.delete();
      for (int i = 1; i <= 4; i++)
         expQ.push_back(beat(i == 4, 4'd9, 32'h610 + 32'(i)));
      checkQueue("t6");
      checkOutput("t6_pkts_after", 64'(statPkts), 64'd1);
      checkOutput("t6_forced_after", 64'(statForced), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
